// File: rtl/picorv32_pcpi_gf_engine_if.sv
// PCPI bus between the PicoRV32 core (master) and a coprocessor (slave).
interface picorv32_pcpi_gf_engine_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );
endinterface

// File: rtl/picorv32_pcpi_gf_engine.sv
// GF(2^m) PCPI coprocessor: digit-serial multiply/reduce, add, square, config.
// Define GF_INV_EN to add Fermat inversion (GFINV, funct3 011).
module picorv32_pcpi_gf_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int DIGIT      = 4
) (
  input logic                      clk,
  input logic                      resetn,
  picorv32_pcpi_gf_engine_if.slave pcpi
);
  localparam int MW   = $clog2(DATA_WIDTH) + 1;
  localparam int NMAX = (DATA_WIDTH + DIGIT - 1) / DIGIT;
  localparam int BW   = NMAX * DIGIT;
  localparam int CW   = $clog2(NMAX + 1);
  localparam int PW   = MW + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_MUL = 3'b000, OP_ADD = 3'b001, OP_SQR = 3'b010, OP_INV = 3'b011, OP_CFG = 3'b111
  } op_t;

  function automatic logic [DATA_WIDTH-1:0] fmask(input logic [MW-1:0] m);
    for (int i = 0; i < DATA_WIDTH; i++) fmask[i] = (i < int'(m));
  endfunction

  // DIGIT chained steps of acc <- (acc*x mod P) ^ (b_i ? A : 0), MSB of the digit first.
  function automatic logic [DATA_WIDTH-1:0] gf_digit(
    input logic [DATA_WIDTH-1:0] acc_in, input logic [DATA_WIDTH-1:0] a,
    input logic [DIGIT-1:0] bits, input logic [MW-1:0] m, input logic [DATA_WIDTH-1:0] p);
    logic [DATA_WIDTH-1:0] r, mk, top;
    logic                  msb;
    mk  = fmask(m);
    top = mk ^ (mk >> 1);
    r   = acc_in;
    for (int j = DIGIT - 1; j >= 0; j--) begin
      msb = |(r & top);
      r   = ((r << 1) & mk) ^ (msb ? p : '0) ^ (bits[j] ? a : '0);
    end
    return r;
  endfunction

  // Left-justify the multiplier so its top digit holds bits N*DIGIT-1 downward.
  function automatic logic [BW-1:0] align_b(input logic [DATA_WIDTH-1:0] b, input logic [CW-1:0] n);
    return BW'(b) << (BW - DIGIT * int'(n));
  endfunction

  state_t                state;
  op_t                   op;
  logic [MW-1:0]         cfg_m, new_m;
  logic [DATA_WIDTH-1:0] cfg_p, new_p;
  logic [CW-1:0]         n_dig, dig_cnt, n_cur;
  logic [DATA_WIDTH-1:0] acc, a_op, acc_nx, mask_cur, op_a, op_b;
  logic [BW-1:0]         b_sh;
  logic [2:0]            f3;
  logic                  hit, accept, last_dig, last_pass, finish, new_ok;
`ifdef GF_INV_EN
  logic [PW-1:0]         pass_cnt;
  logic [DATA_WIDTH-1:0] a_orig;
`endif

  assign f3 = pcpi.pcpi_insn[14:12];

  always_comb begin
    hit = 1'b0;
    if (pcpi.pcpi_insn[6:0] == 7'b0110011 && pcpi.pcpi_insn[31:25] == 7'b0000110) begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b111: hit = 1'b1;
`ifdef GF_INV_EN
        3'b011: hit = 1'b1;
`endif
        default: hit = 1'b0;
      endcase
    end
  end

  assign accept   = (state == S_IDLE) && pcpi.pcpi_valid && hit;
  assign mask_cur = fmask(cfg_m);
  assign op_a     = pcpi.pcpi_rs1[DATA_WIDTH-1:0] & mask_cur;
  assign op_b     = pcpi.pcpi_rs2[DATA_WIDTH-1:0] & mask_cur;
  assign n_cur    = CW'((int'(cfg_m) + DIGIT - 1) / DIGIT);
  assign acc_nx   = gf_digit(acc, a_op, b_sh[BW-1 -: DIGIT], cfg_m, cfg_p);
  assign last_dig = (dig_cnt == CW'(1));
`ifdef GF_INV_EN
  assign last_pass = (op != OP_INV) || (pass_cnt == '0);
`else
  assign last_pass = 1'b1;
`endif
  assign finish = (op == OP_ADD) || (op == OP_CFG) || (last_dig && last_pass);
  assign new_ok = (new_m >= MW'(2)) && (int'(new_m) <= DATA_WIDTH);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= S_IDLE;
      op              <= OP_MUL;
      cfg_m           <= MW'(8);
      cfg_p           <= DATA_WIDTH'(8'h1B);
      n_dig           <= '0;
      dig_cnt         <= '0;
`ifdef GF_INV_EN
      pass_cnt        <= '0;
`endif
      pcpi.pcpi_wr    <= 1'b0;
      pcpi.pcpi_rd    <= '0;
      pcpi.pcpi_wait  <= 1'b0;
      pcpi.pcpi_ready <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          state          <= S_EXEC;
          op             <= op_t'(f3);
          n_dig          <= n_cur;
          dig_cnt        <= n_cur;
`ifdef GF_INV_EN
          pass_cnt       <= PW'(2 * int'(cfg_m) - 4);
`endif
          pcpi.pcpi_wait <= 1'b1;
        end
        S_EXEC: begin
          if (!pcpi.pcpi_valid) begin
            state          <= S_IDLE;
            pcpi.pcpi_wait <= 1'b0;
          end else if (finish) begin
            state           <= S_DONE;
            pcpi.pcpi_wait  <= 1'b0;
            pcpi.pcpi_ready <= 1'b1;
            pcpi.pcpi_wr    <= (op != OP_CFG);
            pcpi.pcpi_rd    <= (op == OP_CFG) ? '0 : 32'((op == OP_ADD) ? acc : acc_nx);
            if (op == OP_CFG && new_ok) begin
              cfg_m <= new_m;
              cfg_p <= new_p;
            end
          end else if (last_dig) begin
            dig_cnt <= n_dig;
`ifdef GF_INV_EN
            pass_cnt <= pass_cnt - PW'(1);
`endif
          end else begin
            dig_cnt <= dig_cnt - CW'(1);
          end
        end
        S_DONE: begin
          state           <= S_IDLE;
          pcpi.pcpi_ready <= 1'b0;
          pcpi.pcpi_wr    <= 1'b0;
          pcpi.pcpi_rd    <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath: operand capture, then one digit per EXEC cycle; INV reloads r between passes.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc   <= (f3 == OP_ADD) ? (op_a ^ op_b) : '0;
      a_op  <= op_a;
      b_sh  <= align_b(((f3 == OP_SQR) || (f3 == OP_INV)) ? op_a : op_b, n_cur);
      new_m <= pcpi.pcpi_rs1[MW-1:0];
      new_p <= pcpi.pcpi_rs2[DATA_WIDTH-1:0] & fmask(pcpi.pcpi_rs1[MW-1:0]);
`ifdef GF_INV_EN
      a_orig <= op_a;
`endif
    end else if (state == S_EXEC) begin
`ifdef GF_INV_EN
      if (last_dig && !last_pass) begin
        acc  <= '0;
        a_op <= acc_nx;
        b_sh <= align_b(pass_cnt[0] ? acc_nx : a_orig, n_dig);
      end else
`endif
      begin
        acc  <= acc_nx;
        b_sh <= b_sh << DIGIT;
      end
    end
  end
endmodule

// File: doc/picorv32_pcpi_gf_engine.md
# picorv32_pcpi_gf_engine

Parametrised PCPI coprocessor for PicoRV32 performing GF(2^m) arithmetic with a runtime-selectable field width m (2..DATA_WIDTH) and reduction polynomial. It sits on the core's PCPI bus next to the existing carry-less ALU path. It adds an iterative digit-serial multiply-and-reduce datapath, field squaring and, optionally, Fermat inversion. All of it is sequenced by one FSM and returns a fully reduced result in one transaction.

## Interface
- DATA_WIDTH, 32: maximum field width; operand/result width (≤32).
- DIGIT, 4: multiplier bits consumed per cycle (1..DATA_WIDTH).
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- pcpi_valid  in  1  core presents instruction; held until pcpi_ready.
- pcpi_insn  in  32  instruction word.
- pcpi_rs1  in  32  operand A / GFCFG width.
- pcpi_rs2  in  32  operand B / GFCFG polynomial.
- pcpi_wr  out  1  result write enable, high only with pcpi_ready.
- pcpi_rd  out  32  result, zero except in DONE.
- pcpi_wait  out  1  busy, high in all EXEC cycles.
- pcpi_ready  out  1  one-cycle completion pulse.

## Operation
- Decode: opcode 7'b0110011, funct7 7'b0000110. funct3 000 GFMUL, 001 GFADD, 010 GFSQR, 011 GFINV, 111 GFCFG. Other funct3 values are ignored, so the core traps.
- Config registers m (reset 8) and P (reset 0x1B) define the field. P holds the low m coefficients; x^m is implicit.
- GFCFG: m ← rs1[$clog2(DATA_WIDTH):0], P ← rs2 masked to m bits. If m<2 or m>DATA_WIDTH, config is unchanged. Always completes with pcpi_wr=0.
- Operands are masked to m bits at capture. The result is always < 2^m and upper bits are zero.
- GFADD: A^B.
- GFMUL: MSB-first interleaved multiply. Let N=ceil(m/DIGIT). Per cycle, for DIGIT bits of B from index N·DIGIT−1 downward: acc ← (acc·x mod P) ^ (b_i ? A : 0), chained DIGIT times combinationally. Bits ≥m are zero and only shift zeros.
- GFSQR: GFMUL with B=A.
- GFINV: r=A; repeat m−2 times {r=r²; r=r·A}; then r=r². That is K=2m−3 multiply passes, back to back, with no gap cycles. Inverse of 0 is 0.
- FSM: IDLE → (pcpi_valid & decoded op) capture operands → EXEC → DONE → IDLE.
  - EXEC lasts 1 cycle for ADD/CFG, N for MUL/SQR, K·N for INV.
  - DONE drives pcpi_ready=1, pcpi_wr=1 (except CFG) and pcpi_rd=result. It returns to IDLE unconditionally.
- pcpi_valid low during EXEC (core abort): return to IDLE next cycle. No ready, no config change.
- resetn low at any time: FSM IDLE, m=8, P=0x1B, all outputs 0, in-flight op discarded.

## Timing
- Reset values: pcpi_wr=0, pcpi_rd=0, pcpi_wait=0, pcpi_ready=0.
- pcpi_valid sampled at edge of cycle n:
  - EXEC starts in cycle n+1 and pcpi_wait rises in n+1.
  - ADD/CFG: ready in n+2.
  - MUL/SQR: ready in n+1+N.
  - INV: ready in n+1+K·N.
- pcpi_wait is low in DONE. All outputs are registered.
- GFCFG config takes effect for any op accepted after its DONE.
- IDLE accepts a new op in the cycle after DONE if valid is high.

## Configuration
- GF_INV_EN defined: GFINV is decoded with the step counter and r/A sequencing above.
- GF_INV_EN undefined: funct3 011 is not decoded, no pass counter is built, and GFINV gets no response (the core raises an illegal-instruction trap). All other ops are unchanged.

## Test plan
- Reset defaults (m=8, P=0x1B, DIGIT=4): GFMUL 0x57,0x83 → rd=0xC1, ready at n+3, wait high in n+1..n+2.
- GFADD 0xFF,0x0F → rd=0xF0 at n+2. Operands 0x1FF,0x0 → rd=0xFF (masking).
- GFSQR 0x80 → 0x9A. GFSQR 0x02 → 0x04.
- GFCFG rs1=4, rs2=0x3, then GFMUL 0x9,0xB → 0xC, ready at n+2. GFCFG rs1=0 → config unchanged, next GFMUL 0x57,0x83 still 0xC1.
- With GF_INV_EN: GFINV 0x53 → 0xCA at n+27. GFINV 0 → 0. Without GF_INV_EN: no pcpi_ready within 20 cycles.
- Drop pcpi_valid in EXEC cycle 5 of GFINV → no ready, IDLE next cycle. Assert resetn low mid-GFMUL → outputs 0 immediately, m=8, P=0x1B.
